cam_frame_writer: RTL and testbench
===================================

Name: cam_frame_writer

Overview:
- Camera capture engine that fills the 15-bit-address, 8-bit-wide video buffer RAM.
- It writes the frames that the UART command controller later reads out with its 0xAA, 0xCC and 0x33 dumps.
- It samples a parallel YUV422 (YUYV) camera bus in the clk domain, keeps only the Y byte of each pixel, decimates in X and Y, and writes one grayscale frame per start request.
- Default geometry: 640x480 source, 160x120 stored image, 19200 bytes at addresses 0..19199.

Parameters:
- DEC_X, 4, keep one pixel out of every DEC_X pixels in a line (pixel = 2 bytes).
- DEC_Y, 4, keep one line out of every DEC_Y lines.
- FRAME_BYTES, 19200, maximum bytes written per frame; address range 0..FRAME_BYTES-1.
- Y_FIRST, 1, 1 = Y is the even byte of each pair (YUYV); 0 = Y is the odd byte (UYVY).

Ports:
- clk  in  1  system clock; must be at least 4x cam_pclk.
- rst  in  1  synchronous, active-high reset.
- cam_pclk  in  1  camera pixel clock, asynchronous, sampled as data.
- cam_vsync  in  1  high during vertical blanking.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  camera data bus.
- start  in  1  one-cycle request to capture the next full frame.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at end of capture.
- frame_short  out  1  valid at done; 1 = frame ended before FRAME_BYTES bytes were written.
- byte_count  out  15  bytes written in the last or current capture.
- ram_address  out  15  RAM address.
- ram_data  out  8  RAM write data.
- ram_wren  out  1  one-cycle write strobe.

Behaviour:
- Reset values:
  - busy, done, frame_short, ram_wren = 0.
  - ram_address, ram_data, byte_count = 0.
  - State = IDLE; all counters and synchronizer flops = 0.
- Input sampling:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through a 2-flop synchronizer.
  - A pclk edge is synced pclk = 1 while its previous value = 0.
  - On a pclk edge, href, vsync and data are taken from the same synchronizer stage.
- States:
  - IDLE: on start, go to WAIT_VS; busy <= 1; byte_count <= 0; ram_address <= 0.
  - WAIT_VS: wait for synced vsync to be seen 1 and then 0. This guarantees the capture begins at a frame top, even if start arrives mid-frame. Then go to CAPTURE; line counter <= 0.
  - CAPTURE:
    - On each pclk edge with href = 1: toggle the byte phase, starting at 0 on each href rise.
    - The Y byte is phase 0 when Y_FIRST = 1, otherwise phase 1.
    - The pixel counter increments after each byte pair.
    - A Y byte is kept when pixel_cnt mod DEC_X == 0, line_cnt mod DEC_Y == 0, and byte_count < FRAME_BYTES.
    - The write occurs in the cycle after the pclk edge: ram_wren = 1, ram_data = Y, ram_address = byte_count.
    - In the next cycle, byte_count and ram_address increment.
    - On an href falling edge: line_cnt increments and pixel_cnt <= 0.
    - On a vsync rising edge: go to DONE.
  - DONE (1 cycle): done = 1; frame_short = (byte_count < FRAME_BYTES); busy <= 0; go to IDLE.
- Boundaries:
  - Once byte_count == FRAME_BYTES, no further writes occur. ram_address holds at FRAME_BYTES-1 and never wraps.
  - The block stays in CAPTURE until vsync rises.
  - start while busy is ignored.
  - rst mid-capture returns to IDLE in the next cycle and suppresses any pending ram_wren.
  - byte_count holds its value after done until the next accepted start.
  - At most one ram_wren per clk; writes are at least 2 clk apart by the pclk ratio.
  - When busy = 0, ram_wren = 0, so the top level may mux the RAM address to the UART controller.

Test Plan:
1. Use DEC_X = 2, DEC_Y = 2, FRAME_BYTES = 8. Pulse start, then send a frame: vsync pulse, 4 lines x 8 pixels. Data byte = line*16 + byte index. Required: exactly 8 writes, to addresses 0..7, with data 00,04,08,0C,20,24,28,2C. done pulses once, frame_short = 0, byte_count = 8.
2. Same setup, but pulse start while a frame is already in progress (href active, vsync low). Required: no writes until after the next vsync 1->0; the capture then matches scenario 1.
3. Same setup with only 2 lines before vsync rises. Required: 4 writes (00,04,08,0C), done with frame_short = 1, byte_count = 4.
4. Use FRAME_BYTES = 6 with the scenario 1 frame. Required: writes stop at address 5, with no write at 6 or 7. done appears at vsync rise with frame_short = 0.
5. Repeat scenario 1 with Y_FIRST = 0. Required: data 01,05,09,0D,21,25,29,2D.
6. Assert rst during line 1 of capture. Required: the next cycle shows busy = 0, ram_wren = 0, ram_address = 0. A subsequent start then captures a clean frame identical to scenario 1.

Source files
------------

// File: rtl/cam_frame_writer.sv
// Captures one decimated grayscale (Y-only) frame from a YUV422 camera bus into an 8-bit video RAM.
// Latency: 3 clk from a camera pclk rise to its RAM write; no backpressure, so the camera bus is never stalled.
module cam_frame_writer #(
    parameter int DEC_X       = 4,
    parameter int DEC_Y       = 4,
    parameter int FRAME_BYTES = 19200,
    parameter int Y_FIRST     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cam_pclk,
    input  logic        i_cam_vsync,
    input  logic        i_cam_href,
    input  logic [7:0]  i_cam_data,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_frame_short,
    output logic [14:0] o_byte_count,
    output logic [14:0] o_ram_address,
    output logic [7:0]  o_ram_data,
    output logic        o_ram_wren
);

    localparam int          XW        = (DEC_X > 1) ? $clog2(DEC_X) : 1;
    localparam int          YW        = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
    localparam logic [14:0] FB15      = 15'(FRAME_BYTES);
    localparam logic [14:0] LAST_ADDR = 15'(FRAME_BYTES - 1);
    localparam logic        Y_PHASE   = (Y_FIRST != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_pclk_s1, r_pclk_s2, r_pclk_d;
    logic        r_href_s1, r_href_s2, r_href_d;
    logic        r_vs_s1, r_vs_s2, r_vs_d;
    logic [7:0]  r_data_s1, r_data_s2;

    logic        r_vs_seen;
    logic        r_phase;
    logic [XW-1:0] r_pix_mod;
    logic [YW-1:0] r_line_mod;
    logic [14:0] r_byte_count;
    logic [14:0] r_ram_address;
    logic [7:0]  r_ram_data;
    logic        r_ram_wren;

    logic        w_pclk_edge;
    logic        w_href_fall;
    logic        w_vs_rise;
    logic        w_keep;

    // Every camera input sees the same two-stage delay, so data, href and
    // vsync sampled at the detected pclk edge belong to that same byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_d <= 1'b0;
            r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_d <= 1'b0;
            r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_d   <= 1'b0;
            r_data_s1 <= '0;   r_data_s2 <= '0;
        end else begin
            r_pclk_s1 <= i_cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_d <= r_pclk_s2;
            r_href_s1 <= i_cam_href;  r_href_s2 <= r_href_s1; r_href_d <= r_href_s2;
            r_vs_s1   <= i_cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_d   <= r_vs_s2;
            r_data_s1 <= i_cam_data;  r_data_s2 <= r_data_s1;
        end
    end

    assign w_pclk_edge = r_pclk_s2 & ~r_pclk_d;
    assign w_href_fall = ~r_href_s2 & r_href_d;
    assign w_vs_rise   = r_vs_s2 & ~r_vs_d;

    // A byte arriving as the frame closes is dropped so no write lands in DONE.
    assign w_keep = (r_state == S_CAPTURE) && w_pclk_edge && r_href_s2 && !w_vs_rise
                 && (r_phase == Y_PHASE) && (r_pix_mod == '0) && (r_line_mod == '0)
                 && (r_byte_count < FB15);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_WAIT_VS;
            S_WAIT_VS: if (r_vs_seen && !r_vs_s2) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_vs_rise) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != S_IDLE);
        o_done        = (r_state == S_DONE);
        o_frame_short = (r_state == S_DONE) && (r_byte_count < FB15);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_seen     <= 1'b0;
            r_phase       <= 1'b0;
            r_pix_mod     <= '0;
            r_line_mod    <= '0;
            r_byte_count  <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
        end else begin
            r_ram_wren <= w_keep;
            if (w_keep) r_ram_data <= r_data_s2;

            case (r_state)
                S_IDLE: begin
                    r_vs_seen <= 1'b0;
                    if (i_start) begin
                        r_byte_count  <= '0;
                        r_ram_address <= '0;
                    end
                end
                S_WAIT_VS: begin
                    if (r_vs_s2) r_vs_seen <= 1'b1;
                    r_phase    <= 1'b0;
                    r_pix_mod  <= '0;
                    r_line_mod <= '0;
                end
                S_CAPTURE: begin
                    if (w_href_fall) begin
                        r_phase    <= 1'b0;
                        r_pix_mod  <= '0;
                        r_line_mod <= (r_line_mod == YW'(DEC_Y - 1)) ? '0 : r_line_mod + 1'b1;
                    end else if (w_pclk_edge && r_href_s2) begin
                        r_phase <= ~r_phase;
                        if (r_phase)
                            r_pix_mod <= (r_pix_mod == XW'(DEC_X - 1)) ? '0 : r_pix_mod + 1'b1;
                    end
                end
                default: ;
            endcase

            // Address follows the count but parks on the last location once the frame is full.
            if (r_ram_wren) begin
                r_byte_count <= r_byte_count + 15'd1;
                if (r_ram_address != LAST_ADDR) r_ram_address <= r_ram_address + 15'd1;
            end
        end
    end

    assign o_byte_count  = r_byte_count;
    assign o_ram_address = r_ram_address;
    assign o_ram_data    = r_ram_data;
    assign o_ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: three instances (base geometry, 6-byte frame limit, UYVY order)
// share one camera bus; expected RAM writes are queued before each frame and popped as writes appear.
module tb_cam_frame_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pclk, vsync, href;
    logic [7:0]  cdata;
    logic        start [3];
    logic        busy  [3];
    logic        done  [3];
    logic        fs    [3];
    logic [14:0] bc    [3];
    logic [14:0] addr  [3];
    logic [7:0]  wdat  [3];
    logic        wren  [3];

    cam_frame_writer #(.DEC_X(2), .DEC_Y(2), .FRAME_BYTES(8), .Y_FIRST(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_cam_pclk(pclk), .i_cam_vsync(vsync), .i_cam_href(href),
        .i_cam_data(cdata), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_frame_short(fs[0]), .o_byte_count(bc[0]), .o_ram_address(addr[0]),
        .o_ram_data(wdat[0]), .o_ram_wren(wren[0]));

    cam_frame_writer #(.DEC_X(2), .DEC_Y(2), .FRAME_BYTES(6), .Y_FIRST(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_cam_pclk(pclk), .i_cam_vsync(vsync), .i_cam_href(href),
        .i_cam_data(cdata), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_frame_short(fs[1]), .o_byte_count(bc[1]), .o_ram_address(addr[1]),
        .o_ram_data(wdat[1]), .o_ram_wren(wren[1]));

    cam_frame_writer #(.DEC_X(2), .DEC_Y(2), .FRAME_BYTES(8), .Y_FIRST(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_cam_pclk(pclk), .i_cam_vsync(vsync), .i_cam_href(href),
        .i_cam_data(cdata), .i_start(start[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_frame_short(fs[2]), .o_byte_count(bc[2]), .o_ram_address(addr[2]),
        .o_ram_data(wdat[2]), .o_ram_wren(wren[2]));

    logic [24:0] sbq [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          dn  [3];
    logic        dfs [3];

    // Advance one clock, then consume any RAM writes against the scoreboard.
    task automatic clk_step();
        logic [24:0] got, exp;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                dn[i]  = dn[i] + 1;
                dfs[i] = fs[i];
            end
            if (wren[i]) begin
                got = {2'(i), addr[i], wdat[i]};
                n_cmp++;
                if (busy[i] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wren_while_idle dut%0d: busy=%0b required 1", i, busy[i]);
                end
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write dut%0d: addr=%0d data=%02h required no write",
                             i, addr[i], wdat[i]);
                end else begin
                    exp = sbq.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL write dut%0d: addr=%0d data=%02h required dut%0d addr=%0d data=%02h",
                                 i, addr[i], wdat[i], exp[24:23], exp[22:8], exp[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic push_expected(input int dut, input int n, input int yoff);
        int line, pix;
        for (int k = 0; k < n; k++) begin
            line = (k / 4) * 2;
            pix  = (k % 4) * 2;
            sbq.push_back({2'(dut), 15'(k), 8'(line * 16 + pix * 2 + yoff)});
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        cdata = d;
        repeat (4) clk_step();
        pclk = 1'b1;
        repeat (4) clk_step();
        pclk = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base);
        href = 1'b1;
        for (int b = 0; b < 16; b++) send_byte(base + 8'(b));
        href = 1'b0;
        repeat (6) clk_step();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (10) clk_step();
        vsync = 1'b0;
        repeat (10) clk_step();
    endtask

    task automatic send_frame(input int nlines);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) send_line(8'(l * 16));
        vsync_pulse();
    endtask

    task automatic pulse_start(input int dut);
        for (int i = 0; i < 3; i++) dn[i] = 0;
        start[dut] = 1'b1;
        clk_step();
        start[dut] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) clk_step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy[i], done[i], fs[i], wren[i], addr[i], wdat[i], bc[i]} !== 42'd0) begin
                n_bad++;
                $display("FAIL reset dut%0d: busy=%0b done=%0b fs=%0b wren=%0b addr=%0d data=%02h bc=%0d required all 0",
                         i, busy[i], done[i], fs[i], wren[i], addr[i], wdat[i], bc[i]);
            end
        end
        rst = 1'b0;
        clk_step();
    endtask

    task automatic test_basic_frame();
        push_expected(0, 8, 0);
        pulse_start(0);
        n_cmp++;
        if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy=%0b required 1", busy[0]); end
        send_frame(4);
        repeat (4) clk_step();
        n_cmp++;
        if (sbq.size() != 0) begin n_bad++; $display("FAIL basic_missing: %0d writes outstanding required 0", sbq.size()); end
        n_cmp++;
        if (dn[0] != 1 || dfs[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_done: done_count=%0d frame_short=%0b required 1 / 0", dn[0], dfs[0]);
        end
        n_cmp++;
        if (bc[0] !== 15'd8 || busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_count: byte_count=%0d busy=%0b required 8 / 0", bc[0], busy[0]);
        end
    endtask

    task automatic test_start_mid_frame();
        push_expected(0, 8, 0);
        for (int i = 0; i < 3; i++) dn[i] = 0;
        fork
            begin
                send_line(8'h80);
                send_line(8'h90);
            end
            begin
                repeat (40) @(posedge clk);
                #1 start[0] = 1'b1;
                @(posedge clk);
                #1 start[0] = 1'b0;
            end
        join
        n_cmp++;
        if (sbq.size() != 8 || busy[0] !== 1'b1) begin
            n_bad++; $display("FAIL midframe_wait: queued=%0d busy=%0b required 8 / 1", sbq.size(), busy[0]);
        end
        send_frame(4);
        repeat (4) clk_step();
        n_cmp++;
        if (sbq.size() != 0 || dn[0] != 1 || dfs[0] !== 1'b0 || bc[0] !== 15'd8) begin
            n_bad++; $display("FAIL midframe_result: queued=%0d done_count=%0d fs=%0b bc=%0d required 0 / 1 / 0 / 8",
                              sbq.size(), dn[0], dfs[0], bc[0]);
        end
    endtask

    task automatic test_short_frame();
        push_expected(0, 4, 0);
        pulse_start(0);
        send_frame(2);
        repeat (4) clk_step();
        n_cmp++;
        if (sbq.size() != 0) begin n_bad++; $display("FAIL short_missing: %0d writes outstanding required 0", sbq.size()); end
        n_cmp++;
        if (dn[0] != 1 || dfs[0] !== 1'b1 || bc[0] !== 15'd4) begin
            n_bad++; $display("FAIL short_done: done_count=%0d fs=%0b bc=%0d required 1 / 1 / 4", dn[0], dfs[0], bc[0]);
        end
    endtask

    task automatic test_frame_limit();
        push_expected(1, 6, 0);
        pulse_start(1);
        send_frame(4);
        repeat (4) clk_step();
        n_cmp++;
        if (sbq.size() != 0) begin n_bad++; $display("FAIL limit_missing: %0d writes outstanding required 0", sbq.size()); end
        n_cmp++;
        if (dn[1] != 1 || dfs[1] !== 1'b0 || bc[1] !== 15'd6) begin
            n_bad++; $display("FAIL limit_done: done_count=%0d fs=%0b bc=%0d required 1 / 0 / 6", dn[1], dfs[1], bc[1]);
        end
        n_cmp++;
        if (addr[1] !== 15'd5) begin n_bad++; $display("FAIL limit_addr_hold: addr=%0d required 5", addr[1]); end
    endtask

    task automatic test_uyvy();
        push_expected(2, 8, 1);
        pulse_start(2);
        send_frame(4);
        repeat (4) clk_step();
        n_cmp++;
        if (sbq.size() != 0 || dn[2] != 1 || dfs[2] !== 1'b0 || bc[2] !== 15'd8) begin
            n_bad++; $display("FAIL uyvy_result: queued=%0d done_count=%0d fs=%0b bc=%0d required 0 / 1 / 0 / 8",
                              sbq.size(), dn[2], dfs[2], bc[2]);
        end
    endtask

    task automatic test_reset_mid_capture();
        push_expected(0, 4, 0);
        pulse_start(0);
        vsync_pulse();
        fork
            begin
                send_line(8'h00);
                send_line(8'h10);
            end
            begin
                repeat (200) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1;
                n_cmp++;
                if ({busy[0], wren[0], addr[0]} !== 17'd0) begin
                    n_bad++; $display("FAIL rst_mid: busy=%0b wren=%0b addr=%0d required 0 / 0 / 0",
                                      busy[0], wren[0], addr[0]);
                end
                rst = 1'b0;
            end
        join
        n_cmp++;
        if (sbq.size() != 0 || dn[0] != 0) begin
            n_bad++; $display("FAIL rst_mid_line0: queued=%0d done_count=%0d required 0 / 0", sbq.size(), dn[0]);
        end
        test_basic_frame();
    endtask

    initial begin
        rst   = 1'b1;
        pclk  = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        cdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            dn[i]    = 0;
            dfs[i]   = 1'b0;
        end
        test_reset();
        test_basic_frame();
        test_start_mid_frame();
        test_short_frame();
        test_frame_limit();
        test_uyvy();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
